// File: rtl/commit_trace_streamer_if.sv
// Trace word stream from the commit streamer to the trace sink (difftest bridge / host log).
interface commit_trace_streamer_if;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_data;
    logic        trace_last;

    modport master (output trace_valid, output trace_data, output trace_last, input trace_ready);
    modport slave  (input trace_valid, input trace_data, input trace_last, output trace_ready);
endinterface

// File: rtl/commit_trace_streamer.sv
// Buffers per-cycle commit records in a FIFO and serializes each one as 32-bit trace words.
// Optional COMMIT_TRACE_SEQ_EN appends a 32-bit commit sequence number as a sixth word.
module commit_trace_streamer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit,
    input  logic [31:0]              commit_instr,
    input  logic [63:0]              commit_pc,
    input  logic [63:0]              commit_pre_pc,
    input  logic                     clear_overflow,
    commit_trace_streamer_if.master  traceIf,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
`ifdef COMMIT_TRACE_SEQ_EN
    localparam int unsigned NW = 6;
`else
    localparam int unsigned NW = 5;
`endif

    typedef enum logic {IDLE, SEND} stateT;

    stateT         state, nextState;
    logic [2:0]    idx, nextIdx;
    logic [31:0]   dataQ, nextData;
    logic [AW-1:0] wrPtr, rdPtr, headPtr;
    logic [AW:0]   level;
    logic          full, popNow, pushAcc, drop, useBypass;

    logic [31:0]   instrMem [DEPTH];
    logic [63:0]   pcMem    [DEPTH];
    logic [63:0]   prePcMem [DEPTH];
    logic [31:0]   hInstr;
    logic [63:0]   hPc, hPrePc;
`ifdef COMMIT_TRACE_SEQ_EN
    logic [31:0]   seqCnt;
    logic [31:0]   seqMem [DEPTH];
    logic [31:0]   hSeq;
`endif

    assign full    = (level == (AW+1)'(DEPTH));
    assign popNow  = (state == SEND) && traceIf.trace_ready && (idx == 3'(NW-1));
    assign pushAcc = commit && (!full || popNow);
    assign drop    = commit && full && !popNow;

    // A record pushed in the same cycle the only queued record pops is forwarded
    // straight from the inputs so the next record starts without a bubble.
    assign hInstr = useBypass ? commit_instr  : instrMem[headPtr];
    assign hPc    = useBypass ? commit_pc     : pcMem[headPtr];
    assign hPrePc = useBypass ? commit_pre_pc : prePcMem[headPtr];
`ifdef COMMIT_TRACE_SEQ_EN
    assign hSeq   = useBypass ? seqCnt        : seqMem[headPtr];
`endif

    always_comb begin
        nextState = state;
        nextIdx   = idx;
        headPtr   = rdPtr;
        useBypass = 1'b0;
        nextData  = '0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    nextState = SEND;
                    nextIdx   = '0;
                end
            end
            SEND: begin
                if (traceIf.trace_ready) begin
                    if (idx == 3'(NW-1)) begin
                        nextIdx = '0;
                        headPtr = rdPtr + AW'(1);
                        if (level > (AW+1)'(1)) begin
                            nextState = SEND;
                        end else if (pushAcc) begin
                            useBypass = 1'b1;
                        end else begin
                            nextState = IDLE;
                        end
                    end else begin
                        nextIdx = idx + 3'd1;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
        if (nextState == SEND) begin
            case (nextIdx)
                3'd0:    nextData = hInstr;
                3'd1:    nextData = hPc[31:0];
                3'd2:    nextData = hPc[63:32];
                3'd3:    nextData = hPrePc[31:0];
                3'd4:    nextData = hPrePc[63:32];
`ifdef COMMIT_TRACE_SEQ_EN
                default: nextData = hSeq;
`else
                default: nextData = '0;
`endif
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
            dataQ <= '0;
        end else begin
            state <= nextState;
            idx   <= nextIdx;
            dataQ <= nextData;
        end
    end

    always_ff @(posedge clk) begin
        if (pushAcc) begin
            instrMem[wrPtr] <= commit_instr;
            pcMem[wrPtr]    <= commit_pc;
            prePcMem[wrPtr] <= commit_pre_pc;
`ifdef COMMIT_TRACE_SEQ_EN
            seqMem[wrPtr]   <= seqCnt;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (pushAcc) wrPtr <= wrPtr + AW'(1);
            if (popNow)  rdPtr <= rdPtr + AW'(1);
            if (pushAcc && !popNow)      level <= level + (AW+1)'(1);
            else if (!pushAcc && popNow) level <= level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear_overflow) begin
            overflow <= drop;
            drop_cnt <= drop ? CNT_W'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

`ifdef COMMIT_TRACE_SEQ_EN
    // Counts every commit pulse, dropped ones included, so gaps in w5 expose drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        seqCnt <= '0;
        else if (commit) seqCnt <= seqCnt + 32'd1;
    end
`endif

    assign traceIf.trace_valid = (state == SEND);
    assign traceIf.trace_last  = (state == SEND) && (idx == 3'(NW-1));
    assign traceIf.trace_data  = dataQ;
    assign fifo_level          = level;

endmodule

// File: tb/tb_commit_trace_streamer.sv
// Self-checking bench for commit_trace_streamer: record table plus scoreboard of expected trace words.
module tb_commit_trace_streamer;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 3;
`ifdef COMMIT_TRACE_SEQ_EN
    localparam int unsigned NW = 6;
`else
    localparam int unsigned NW = 5;
`endif

    typedef struct packed {
        logic [31:0]      instr;
        logic [63:0]      pc;
        logic [63:0]      prePc;
        logic [4:0][31:0] expW;
    } vecT;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   commit = 1'b0;
    logic                   clearOvf = 1'b0;
    logic [31:0]            cInstr = '0;
    logic [63:0]            cPc = '0;
    logic [63:0]            cPre = '0;
    logic [$clog2(DEPTH):0] level;
    logic                   ovf;
    logic [CNT_W-1:0]       dropCnt;

    commit_trace_streamer_if tIf();

    commit_trace_streamer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .commit         (commit),
        .commit_instr   (cInstr),
        .commit_pc      (cPc),
        .commit_pre_pc  (cPre),
        .clear_overflow (clearOvf),
        .traceIf        (tIf),
        .fifo_level     (level),
        .overflow       (ovf),
        .drop_cnt       (dropCnt)
    );

    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [32:0] expQ[$];
    logic [31:0] seqModel = '0;
    int          runLen = 0;
    int          maxRun = 0;
    vecT         tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0][31:0] mkWords(input logic [31:0] instr, input logic [63:0] pc,
                                                 input logic [63:0] pre);
        return {pre[63:32], pre[31:0], pc[63:32], pc[31:0], instr};
    endfunction

    task automatic doCommit(input logic [31:0] instr, input logic [63:0] pc, input logic [63:0] pre,
                            input logic [4:0][31:0] w, input bit accept);
        logic [31:0] words[6];
        for (int i = 0; i < 5; i++) words[i] = w[i];
        words[5] = seqModel;
        cInstr = instr;
        cPc    = pc;
        cPre   = pre;
        commit = 1'b1;
        if (accept) begin
            for (int i = 0; i < NW; i++) expQ.push_back({(i == NW - 1), words[i]});
        end
        seqModel++;
        @(posedge clk);
        #1;
        commit = 1'b0;
    endtask

    task automatic genCommit(input int n, input bit accept);
        logic [31:0] instr;
        logic [63:0] pc, pre;
        instr = 32'h0C00_0000 + 32'(n);
        pc    = {32'hA000_0000 + 32'(n), 32'h0000_1000 + 32'(n * 4)};
        pre   = {32'hB000_0000 + 32'(n), 32'h0000_1004 + 32'(n * 4)};
        doCommit(instr, pc, pre, mkWords(instr, pc, pre), accept);
    endtask

    task automatic waitDrain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (expQ.size() == 0 && !tIf.trace_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain_pending_words", 64'(expQ.size()), 64'd0);
        check("drain_valid_low", 64'(tIf.trace_valid), 64'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_valid"}, 64'(tIf.trace_valid), 64'd0);
        check({tag, "_data"},  64'(tIf.trace_data),  64'd0);
        check({tag, "_last"},  64'(tIf.trace_last),  64'd0);
        check({tag, "_level"}, 64'(level),           64'd0);
        check({tag, "_ovf"},   64'(ovf),             64'd0);
        check({tag, "_drop"},  64'(dropCnt),         64'd0);
    endtask

    // Scoreboard pop on every handshake, plus hold-stability of a stalled word.
    initial begin
        logic        pend;
        logic [32:0] pendVal;
        logic [32:0] e;
        pend = 1'b0;
        pendVal = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0;
                runLen = 0;
            end else begin
                if (tIf.trace_valid) runLen++;
                else runLen = 0;
                if (runLen > maxRun) maxRun = runLen;
                if (pend) begin
                    check("hold_valid", 64'(tIf.trace_valid), 64'd1);
                    check("hold_word", 64'({tIf.trace_last, tIf.trace_data}), 64'(pendVal));
                end
                if (tIf.trace_valid && tIf.trace_ready) begin
                    if (expQ.size() == 0) begin
                        nChecks++;
                        nFails++;
                        $display("FAIL unexpected_word: got 0x%0h, expected no word",
                                 {tIf.trace_last, tIf.trace_data});
                    end else begin
                        e = expQ.pop_front();
                        check("stream_word", 64'({tIf.trace_last, tIf.trace_data}), 64'(e));
                    end
                    pend = 1'b0;
                end else if (tIf.trace_valid) begin
                    pend = 1'b1;
                    pendVal = {tIf.trace_last, tIf.trace_data};
                end else begin
                    pend = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        tbl[0] = '{32'h0000_0013, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0004,
                   {32'h0000_0000, 32'h8000_0004, 32'h0000_0000, 32'h8000_0000, 32'h0000_0013}};
        tbl[1] = '{32'hFFFF_FFFF, 64'hDEAD_BEEF_0000_1000, 64'h0123_4567_89AB_CDEF,
                   {32'h0123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF, 32'h0000_1000, 32'hFFFF_FFFF}};
        tbl[2] = '{32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000,
                   {32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000}};
        tbl[3] = '{32'hA5A5_5A5A, 64'h0000_0001_0000_0000, 64'h8000_0000_0000_0002,
                   {32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 32'hA5A5_5A5A}};
        tIf.trace_ready = 1'b0;

        #12;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single record: one cycle from push to first word.
        tIf.trace_ready = 1'b1;
        doCommit(tbl[0].instr, tbl[0].pc, tbl[0].prePc, tbl[0].expW, 1'b1);
        check("lat_level_after_push", 64'(level), 64'd1);
        check("lat_valid_after_push", 64'(tIf.trace_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_first_valid", 64'(tIf.trace_valid), 64'd1);
        check("lat_first_word", 64'(tIf.trace_data), 64'h13);
        waitDrain(40);
        check("single_level_end", 64'(level), 64'd0);

        // Remaining table records back to back: one unbroken valid run.
        maxRun = 0;
        for (int i = 1; i < 4; i++)
            doCommit(tbl[i].instr, tbl[i].pc, tbl[i].prePc, tbl[i].expW, 1'b1);
        waitDrain(60);
        check("b2b_valid_run", 64'(maxRun), 64'(3 * NW));

        // Sink stalled: 8 fill the FIFO, 2 are dropped.
        tIf.trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) genCommit(i, i < 8);
        check("full_level", 64'(level), 64'(DEPTH));
        check("full_overflow", 64'(ovf), 64'd1);
        check("full_drop_cnt", 64'(dropCnt), 64'd2);
        tIf.trace_ready = 1'b1;
        waitDrain(8 * NW + 20);
        check("drained_overflow_sticky", 64'(ovf), 64'd1);
        clearOvf = 1'b1;
        @(posedge clk);
        #1;
        clearOvf = 1'b0;
        check("clear_overflow", 64'(ovf), 64'd0);
        check("clear_drop_cnt", 64'(dropCnt), 64'd0);

        // Ready toggling mid-record.
        tIf.trace_ready = 1'b0;
        genCommit(20, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tIf.trace_ready = (i % 2) == 1;
            @(posedge clk);
            #1;
        end
        tIf.trace_ready = 1'b1;
        waitDrain(40);

        // Full FIFO, commit coincident with the final-word handshake.
        tIf.trace_ready = 1'b0;
        for (int i = 0; i < 8; i++) genCommit(30 + i, 1'b1);
        check("coin_level_before", 64'(level), 64'(DEPTH));
        tIf.trace_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tIf.trace_valid && tIf.trace_last) begin
                found = 1'b1;
                break;
            end
        end
        check("coin_found_last", 64'(found), 64'd1);
        genCommit(40, 1'b1);
        check("coin_level_after", 64'(level), 64'(DEPTH));
        check("coin_drop_cnt", 64'(dropCnt), 64'd0);
        check("coin_overflow", 64'(ovf), 64'd0);
        waitDrain(9 * NW + 20);

        // Saturating drop counter, then clear coincident with a drop.
        tIf.trace_ready = 1'b0;
        for (int i = 0; i < 17; i++) genCommit(50 + i, i < 8);
        check("sat_drop_cnt", 64'(dropCnt), 64'd7);
        check("sat_overflow", 64'(ovf), 64'd1);
        clearOvf = 1'b1;
        genCommit(70, 1'b0);
        clearOvf = 1'b0;
        check("clrdrop_drop_cnt", 64'(dropCnt), 64'd1);
        check("clrdrop_overflow", 64'(ovf), 64'd1);
        tIf.trace_ready = 1'b1;
        waitDrain(8 * NW + 20);
        clearOvf = 1'b1;
        @(posedge clk);
        #1;
        clearOvf = 1'b0;

        // Asynchronous reset while w2 of a record is on the bus.
        doCommit(32'h0000_0777, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF4,
                 mkWords(32'h0000_0777, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF4), 1'b1);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tIf.trace_valid && tIf.trace_data == 32'h1234_5678) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_found_w2", 64'(found), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        checkResetOutputs("midrst");
        expQ.delete();
        seqModel = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        genCommit(80, 1'b1);
        @(posedge clk);
        #1;
        check("post_rst_first_word", 64'(tIf.trace_data), 64'h0C00_0050);
        waitDrain(40);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
